// File: rtl/axi_cdma_xfer_sched.sv
// -----------------------------------------------------------------------------
// axi_cdma_xfer_sched
//
// Splits one large copy request into CDMA descriptors of at most MAX_SEG_LEN
// bytes. At most MAX_OUTSTANDING descriptors are in flight. CDMA completions
// are counted and their errors are folded into one status per request.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   s_axis_req_*                 copy request in (read/write addr, len, tag)
//   m_axis_desc_*                CDMA descriptor out (addr, len, seq tag)
//   s_axis_desc_status_*         CDMA completion in (tag unused, error)
//   m_axis_req_status_*          one-cycle aggregated completion pulse
//   busy                         high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module axi_cdma_xfer_sched #(
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH       = 20,
    parameter int REQ_LEN_WIDTH   = 32,
    parameter int REQ_TAG_WIDTH   = 8,
    parameter int DESC_TAG_WIDTH  = 8,
    parameter int MAX_SEG_LEN     = 4096,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic [AXI_ADDR_WIDTH-1:0] s_axis_req_read_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axis_req_write_addr,
    input  logic [REQ_LEN_WIDTH-1:0]  s_axis_req_len,
    input  logic [REQ_TAG_WIDTH-1:0]  s_axis_req_tag,
    input  logic                      s_axis_req_valid,
    output logic                      s_axis_req_ready,

    output logic [AXI_ADDR_WIDTH-1:0] m_axis_desc_read_addr,
    output logic [AXI_ADDR_WIDTH-1:0] m_axis_desc_write_addr,
    output logic [LEN_WIDTH-1:0]      m_axis_desc_len,
    output logic [DESC_TAG_WIDTH-1:0] m_axis_desc_tag,
    output logic                      m_axis_desc_valid,
    input  logic                      m_axis_desc_ready,

    input  logic [DESC_TAG_WIDTH-1:0] s_axis_desc_status_tag,
    input  logic [3:0]                s_axis_desc_status_error,
    input  logic                      s_axis_desc_status_valid,

    output logic [REQ_TAG_WIDTH-1:0]  m_axis_req_status_tag,
    output logic [3:0]                m_axis_req_status_error,
    output logic                      m_axis_req_status_valid,

    output logic                      busy
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [REQ_LEN_WIDTH-1:0] SEG_MAX = REQ_LEN_WIDTH'(MAX_SEG_LEN);
    localparam logic [OUT_W-1:0]         OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        STATUS    = 2'd3
    } state_t;

    state_t                    state;
    // Pointers describe the next segment not yet loaded into the output
    // register; the output register holds the segment being offered.
    logic [AXI_ADDR_WIDTH-1:0] rd_ptr;
    logic [AXI_ADDR_WIDTH-1:0] wr_ptr;
    logic [REQ_LEN_WIDTH-1:0]  rem;
    logic [DESC_TAG_WIDTH-1:0] seq;
    logic [REQ_TAG_WIDTH-1:0]  req_tag;
    logic [3:0]                err;
    logic [OUT_W-1:0]          outstanding;

    logic                      desc_hs;
    logic                      stat_ev;
    logic                      desc_free;
    logic                      load;
    logic                      issue_done;
    logic [REQ_LEN_WIDTH-1:0]  seg;
    logic [OUT_W-1:0]          out_nxt;
    logic [3:0]                err_nxt;

    // CDMA completes in order, so only the completion count matters.
    logic unused_status_tag;
    assign unused_status_tag = ^s_axis_desc_status_tag;

    always_comb begin
        desc_hs   = m_axis_desc_valid && m_axis_desc_ready;
        // Completions are ignored in IDLE and never underflow the counter,
        // so late statuses from before a reset are harmless.
        stat_ev   = s_axis_desc_status_valid && (state != IDLE) && (outstanding != '0);
        out_nxt   = outstanding + OUT_W'(desc_hs) - OUT_W'(stat_ev);
        err_nxt   = err;
        if (err == 4'd0 && stat_ev)
            err_nxt = s_axis_desc_status_error;
        seg       = (rem < SEG_MAX) ? rem : SEG_MAX;
        desc_free = !m_axis_desc_valid || m_axis_desc_ready;
        // A new descriptor is loaded only when its credit is already secured
        // for the cycle it appears, so valid is never raised and then held
        // off by the credit limit. An error seen this cycle blocks the load.
        load       = (state == ISSUE) && desc_free && (rem != '0) &&
                     (err_nxt == 4'd0) && (out_nxt < OUT_MAX);
        issue_done = desc_free && ((rem == '0) || (err_nxt != 4'd0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                   <= IDLE;
            rd_ptr                  <= '0;
            wr_ptr                  <= '0;
            rem                     <= '0;
            seq                     <= '0;
            req_tag                 <= '0;
            err                     <= '0;
            outstanding             <= '0;
            s_axis_req_ready        <= 1'b0;
            m_axis_desc_read_addr   <= '0;
            m_axis_desc_write_addr  <= '0;
            m_axis_desc_len         <= '0;
            m_axis_desc_tag         <= '0;
            m_axis_desc_valid       <= 1'b0;
            m_axis_req_status_tag   <= '0;
            m_axis_req_status_error <= '0;
            m_axis_req_status_valid <= 1'b0;
            busy                    <= 1'b0;
        end else begin
            m_axis_req_status_valid <= 1'b0;

            if (state != IDLE) begin
                outstanding <= out_nxt;
                err         <= err_nxt;
            end

            if (load) begin
                m_axis_desc_read_addr  <= rd_ptr;
                m_axis_desc_write_addr <= wr_ptr;
                m_axis_desc_len        <= LEN_WIDTH'(seg);
                m_axis_desc_tag        <= seq;
                rd_ptr                 <= rd_ptr + AXI_ADDR_WIDTH'(seg);
                wr_ptr                 <= wr_ptr + AXI_ADDR_WIDTH'(seg);
                rem                    <= rem - seg;
                seq                    <= seq + 1'b1;
                m_axis_desc_valid      <= 1'b1;
            end else if (desc_hs) begin
                m_axis_desc_valid      <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Ready comes up one cycle after entering IDLE, which
                    // leaves a cycle between a status pulse and the next accept.
                    s_axis_req_ready <= 1'b1;
                    if (s_axis_req_valid && s_axis_req_ready) begin
                        s_axis_req_ready <= 1'b0;
                        rd_ptr           <= s_axis_req_read_addr;
                        wr_ptr           <= s_axis_req_write_addr;
                        rem              <= s_axis_req_len;
                        req_tag          <= s_axis_req_tag;
                        err              <= '0;
                        seq              <= '0;
                        outstanding      <= '0;
                        busy             <= 1'b1;
                        state            <= (s_axis_req_len == '0) ? STATUS : ISSUE;
                    end
                end
                ISSUE: begin
                    // Skip WAIT_DONE when the last completion lands right as
                    // issuing ends, keeping completion-to-status at 2 cycles.
                    if (issue_done)
                        state <= (out_nxt == '0) ? STATUS : WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (out_nxt == '0)
                        state <= STATUS;
                end
                STATUS: begin
                    m_axis_req_status_valid <= 1'b1;
                    m_axis_req_status_tag   <= req_tag;
                    m_axis_req_status_error <= err;
                    busy                    <= 1'b0;
                    state                   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_cdma_xfer_sched.sv
// -----------------------------------------------------------------------------
// tb_axi_cdma_xfer_sched
//
// Drives copy requests, models the CDMA (in-order completions, optional error
// injection, randomized ready/status timing) and checks every descriptor and
// request status against a segment list computed directly from the request.
// -----------------------------------------------------------------------------
module tb_axi_cdma_xfer_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req_read_addr, req_write_addr;
    logic [31:0] req_len;
    logic [7:0]  req_tag;
    logic        req_valid, req_ready;
    logic [15:0] desc_read_addr, desc_write_addr;
    logic [19:0] desc_len;
    logic [7:0]  desc_tag;
    logic        desc_valid, desc_ready;
    logic [7:0]  stat_tag;
    logic [3:0]  stat_error;
    logic        stat_valid;
    logic [7:0]  rs_tag;
    logic [3:0]  rs_error;
    logic        rs_valid;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    axi_cdma_xfer_sched dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .s_axis_req_read_addr    (req_read_addr),
        .s_axis_req_write_addr   (req_write_addr),
        .s_axis_req_len          (req_len),
        .s_axis_req_tag          (req_tag),
        .s_axis_req_valid        (req_valid),
        .s_axis_req_ready        (req_ready),
        .m_axis_desc_read_addr   (desc_read_addr),
        .m_axis_desc_write_addr  (desc_write_addr),
        .m_axis_desc_len         (desc_len),
        .m_axis_desc_tag         (desc_tag),
        .m_axis_desc_valid       (desc_valid),
        .m_axis_desc_ready       (desc_ready),
        .s_axis_desc_status_tag  (stat_tag),
        .s_axis_desc_status_error(stat_error),
        .s_axis_desc_status_valid(stat_valid),
        .m_axis_req_status_tag   (rs_tag),
        .m_axis_req_status_error (rs_error),
        .m_axis_req_status_valid (rs_valid),
        .busy                    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic idle_inputs();
        req_valid  = 1'b0;
        desc_ready = 1'b0;
        stat_valid = 1'b0;
        stat_tag   = '0;
        stat_error = '0;
    endtask

    // One request end to end. rmode: 0 ready=1, 1 random, 2 low for rel 6..10.
    // smode: 0 complete asap, 1 random delay, 2 withhold except rel 30 and >=40.
    // err_tag >= 0 makes that descriptor's completion carry err_code.
    // abort_at >= 0 asserts reset at that relative cycle and returns.
    task automatic run_req(input logic [15:0] ra, input logic [15:0] wa,
                           input logic [31:0] len, input logic [7:0] tag,
                           input int rmode, input int smode, input int err_tag,
                           input logic [3:0] err_code, input int abort_at,
                           output int n_hs);
        logic [15:0] e_ra[$], e_wa[$];
        logic [19:0] e_len[$];
        logic [7:0]  e_tag[$];
        logic [7:0]  pend[$];
        longint      rem, seg;
        logic [15:0] r, w;
        int          seq, rel, acc_cyc, last_stat, err_cyc, inflight, hs;
        bit          accepted, first_seen, done, rdy, st, p_valid, p_ready;
        logic [3:0]  exp_err, st_err;
        logic [7:0]  t;
        logic [15:0] p_ra, p_wa;
        logic [19:0] p_len;
        logic [7:0]  p_tag;

        rem = len; r = ra; w = wa; seq = 0;
        while (rem > 0) begin
            seg = (rem > 4096) ? 4096 : rem;
            e_ra.push_back(r); e_wa.push_back(w);
            e_len.push_back(20'(seg)); e_tag.push_back(8'(seq));
            r = r + 16'(seg); w = w + 16'(seg);
            rem = rem - seg; seq++;
        end

        accepted = 0; first_seen = 0; done = 0; p_valid = 0; p_ready = 0;
        acc_cyc = 0; last_stat = -100; err_cyc = -1; inflight = 0; hs = 0;
        exp_err = 4'd0;
        p_ra = '0; p_wa = '0; p_len = '0; p_tag = '0;
        req_read_addr = ra; req_write_addr = wa; req_len = len; req_tag = tag;

        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            rel = accepted ? (cyc - acc_cyc) : -1;

            if (abort_at >= 0 && rel == abort_at) begin
                rst_n = 1'b0;
                idle_inputs();
                #1;
                checks++;
                if (desc_valid !== 1'b0 || rs_valid !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL async_reset: desc_valid=%b rs_valid=%b ready=%b busy=%b required all 0",
                             desc_valid, rs_valid, req_ready, busy);
                end
                n_hs = hs;
                return;
            end

            if (p_valid && !p_ready) begin
                checks++;
                if (desc_valid !== 1'b1 || desc_read_addr !== p_ra || desc_write_addr !== p_wa ||
                    desc_len !== p_len || desc_tag !== p_tag) begin
                    failures++;
                    $display("FAIL desc_hold: got v=%b %h/%h/%0d/%0d required v=1 %h/%h/%0d/%0d",
                             desc_valid, desc_read_addr, desc_write_addr, desc_len, desc_tag,
                             p_ra, p_wa, p_len, p_tag);
                end
            end

            if (desc_valid === 1'b1 && !first_seen) begin
                first_seen = 1;
                checks++;
                if (rel !== 2) begin
                    failures++;
                    $display("FAIL first_desc_latency: got %0d required 2", rel);
                end
            end

            if (rs_valid === 1'b1) begin
                done = 1;
                checks++;
                if (!accepted || rs_tag !== tag || rs_error !== exp_err || inflight != 0 ||
                    (exp_err == 4'd0 && e_ra.size() != 0) || req_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL req_status: tag=%h err=%0d inflight=%0d left=%0d ready=%b required tag=%h err=%0d inflight=0 ready=0",
                             rs_tag, rs_error, inflight, e_ra.size(), req_ready, tag, exp_err);
                end
                checks++;
                if ((len == 0 && rel != 2) || (len != 0 && cyc - last_stat != 2)) begin
                    failures++;
                    $display("FAIL status_latency: rel=%0d since_last=%0d required 2",
                             rel, cyc - last_stat);
                end
            end else if (accepted && rel >= 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy: got %b required 1 at rel %0d", busy, rel);
                end
            end

            if (done) begin
                idle_inputs();
            end else begin
                req_valid = !accepted;
                if (!accepted && req_ready === 1'b1) begin
                    accepted = 1;
                    acc_cyc  = cyc;
                end

                case (rmode)
                    0:       rdy = 1;
                    1:       rdy = ($urandom_range(3) != 0);
                    default: rdy = !(rel >= 6 && rel <= 10);
                endcase
                desc_ready = rdy;

                case (smode)
                    0:       st = (pend.size() != 0);
                    1:       st = (pend.size() != 0) && ($urandom_range(1) == 1);
                    default: st = (pend.size() != 0) && (rel == 30 || rel >= 40);
                endcase
                stat_valid = st;
                stat_error = 4'd0;
                if (st) begin
                    t = pend.pop_front();
                    st_err = (err_tag >= 0 && int'(t) == err_tag) ? err_code : 4'd0;
                    stat_tag   = t;
                    stat_error = st_err;
                    if (st_err != 4'd0 && exp_err == 4'd0) begin
                        exp_err = st_err;
                        err_cyc = cyc;
                    end
                    last_stat = cyc;
                end

                if (desc_valid === 1'b1 && rdy) begin
                    checks++;
                    if (e_ra.size() == 0) begin
                        failures++;
                        $display("FAIL desc_extra: got %h/%h/%0d/%0d required none",
                                 desc_read_addr, desc_write_addr, desc_len, desc_tag);
                    end else begin
                        if (desc_read_addr !== e_ra[0] || desc_write_addr !== e_wa[0] ||
                            desc_len !== e_len[0] || desc_tag !== e_tag[0]) begin
                            failures++;
                            $display("FAIL desc_fields: got %h/%h/%0d/%0d required %h/%h/%0d/%0d",
                                     desc_read_addr, desc_write_addr, desc_len, desc_tag,
                                     e_ra[0], e_wa[0], e_len[0], e_tag[0]);
                        end
                        void'(e_ra.pop_front()); void'(e_wa.pop_front());
                        void'(e_len.pop_front()); void'(e_tag.pop_front());
                    end
                    checks++;
                    if (inflight >= 4 || (err_cyc >= 0 && cyc > err_cyc)) begin
                        failures++;
                        $display("FAIL desc_issue_rule: inflight=%0d err_cyc=%0d cyc=%0d required inflight<4 and no issue after error",
                                 inflight, err_cyc, cyc);
                    end
                    pend.push_back(desc_tag);
                    hs++;
                    inflight++;
                end
                if (st) inflight--;

                if (smode == 2 && (rel == 29 || rel == 39)) begin
                    checks++;
                    if (hs != (rel == 29 ? 4 : 5) || desc_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL credit_limit: issued=%0d valid=%b required %0d and 0",
                                 hs, desc_valid, (rel == 29 ? 4 : 5));
                    end
                end
            end

            p_valid = (desc_valid === 1'b1); p_ready = desc_ready;
            p_ra = desc_read_addr; p_wa = desc_write_addr; p_len = desc_len; p_tag = desc_tag;
        end

        idle_inputs();
        n_hs = hs;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL req_timeout: no status pulse for tag %h", tag);
        end else begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1 || busy !== 1'b0 || rs_valid !== 1'b0) begin
                failures++;
                $display("FAIL post_status: ready=%b busy=%b pulse=%b required 1 0 0",
                         req_ready, busy, rs_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        req_read_addr = '0; req_write_addr = '0; req_len = '0; req_tag = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (desc_valid !== 1'b0 || rs_valid !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b0 ||
            desc_len !== 20'd0 || desc_read_addr !== 16'd0 || rs_tag !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: dv=%b sv=%b rdy=%b busy=%b len=%0d ra=%h required all 0",
                     desc_valid, rs_valid, req_ready, busy, desc_len, desc_read_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: ready=%b busy=%b required 1 0", req_ready, busy);
        end
    endtask

    task automatic test_basic();
        int n;
        run_req(16'h1000, 16'h8000, 32'd10000, 8'h11, 0, 0, -1, 4'd0, -1, n);
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL basic_count: got %0d required 3", n);
        end
    endtask

    task automatic test_zero_len();
        int n;
        run_req(16'h0040, 16'h0080, 32'd0, 8'h5A, 0, 0, -1, 4'd0, -1, n);
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL zero_len_count: got %0d required 0", n);
        end
    endtask

    task automatic test_credit();
        int n;
        run_req(16'h2000, 16'h6000, 32'd40960, 8'hC3, 0, 2, -1, 4'd0, -1, n);
        checks++;
        if (n != 10) begin
            failures++;
            $display("FAIL credit_count: got %0d required 10", n);
        end
    endtask

    task automatic test_error();
        int n;
        run_req(16'h0000, 16'h4000, 32'd40960, 8'hE7, 0, 0, 1, 4'd3, -1, n);
        checks++;
        if (n >= 10 || n < 2) begin
            failures++;
            $display("FAIL error_abort_count: got %0d required 2..9", n);
        end
    endtask

    task automatic test_backpressure();
        int n;
        run_req(16'hF800, 16'hFC00, 32'd20487, 8'h3C, 2, 0, -1, 4'd0, -1, n);
        checks++;
        if (n != 6) begin
            failures++;
            $display("FAIL backpressure_count: got %0d required 6", n);
        end
    endtask

    task automatic test_random();
        int n, exp_n;
        logic [31:0] len;
        for (int i = 0; i < 6; i++) begin
            len   = $urandom_range(20000);
            exp_n = (len + 4095) / 4096;
            run_req(16'($urandom), 16'($urandom), len, 8'($urandom), 1, 1, -1, 4'd0, -1, n);
            checks++;
            if (n != exp_n) begin
                failures++;
                $display("FAIL random_count: len=%0d got %0d required %0d", len, n, exp_n);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        run_req(16'h3000, 16'h7000, 32'd40960, 8'h99, 0, 2, -1, 4'd0, 5, n);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // Stale completions from the aborted transfer arrive while idle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stat_valid = 1'b1;
            stat_tag   = 8'(i);
            stat_error = 4'd7;
        end
        @(negedge clk);
        idle_inputs();
        run_req(16'h0200, 16'h0300, 32'd100, 8'h77, 0, 0, -1, 4'd0, -1, n);
        checks++;
        if (n != 1) begin
            failures++;
            $display("FAIL reset_recover_count: got %0d required 1", n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_credit();
        test_error();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_cdma_xfer_sched.md
Name: axi_cdma_xfer_sched

Overview:
- Sequences the AXI CDMA core for large copy requests.
- Accepts one copy request (read addr, write addr, length up to REQ_LEN_WIDTH bits) and splits it into CDMA descriptors of at most MAX_SEG_LEN bytes.
- Limits in-flight descriptors to MAX_OUTSTANDING and collects CDMA status.
- Emits one aggregated completion status per request; sits between a software/queue front end and the CDMA descriptor port or descriptor mux.

Parameters:
- AXI_ADDR_WIDTH, 16, address width of read/write addresses.
- LEN_WIDTH, 20, CDMA descriptor length width; MAX_SEG_LEN must be ≤ 2**LEN_WIDTH-1.
- REQ_LEN_WIDTH, 32, request length width.
- REQ_TAG_WIDTH, 8, request tag width.
- DESC_TAG_WIDTH, 8, CDMA descriptor tag width; must be ≥ $clog2(MAX_OUTSTANDING)+1.
- MAX_SEG_LEN, 4096, maximum bytes per descriptor.
- MAX_OUTSTANDING, 4, maximum issued-but-uncompleted descriptors (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axis_req_read_addr  in  AXI_ADDR_WIDTH  source address.
- s_axis_req_write_addr  in  AXI_ADDR_WIDTH  destination address.
- s_axis_req_len  in  REQ_LEN_WIDTH  total bytes.
- s_axis_req_tag  in  REQ_TAG_WIDTH  request tag.
- s_axis_req_valid  in  1  request valid.
- s_axis_req_ready  out  1  request accepted.
- m_axis_desc_read_addr  out  AXI_ADDR_WIDTH  segment source.
- m_axis_desc_write_addr  out  AXI_ADDR_WIDTH  segment destination.
- m_axis_desc_len  out  LEN_WIDTH  segment bytes.
- m_axis_desc_tag  out  DESC_TAG_WIDTH  segment sequence number, modulo 2**DESC_TAG_WIDTH.
- m_axis_desc_valid  out  1  descriptor valid.
- m_axis_desc_ready  in  1  CDMA accepts descriptor.
- s_axis_desc_status_tag  in  DESC_TAG_WIDTH  completed segment tag.
- s_axis_desc_status_error  in  4  completion error code.
- s_axis_desc_status_valid  in  1  completion pulse.
- m_axis_req_status_tag  out  REQ_TAG_WIDTH  finished request tag.
- m_axis_req_status_error  out  4  first nonzero segment error, else 0.
- m_axis_req_status_valid  out  1  single-cycle completion pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - All valid outputs 0, s_axis_req_ready 0, busy 0.
  - Counters 0, data registers 0.
  - First cycle after deassertion: s_axis_req_ready = 1.
  - Reset mid-transfer drops all bookkeeping; late CDMA statuses arriving in IDLE are ignored.
- IDLE:
  - s_axis_req_ready = 1.
  - On req handshake, latch addr/len/tag, clear error and seq counter.
  - len == 0 -> STATUS; otherwise -> ISSUE.
- ISSUE:
  - seg = min(remaining, MAX_SEG_LEN).
  - Descriptor output is registered; valid rises the cycle after entering ISSUE.
  - Valid and data are held stable until ready; no retraction.
  - While outstanding == MAX_OUTSTANDING, valid stays low (not raised).
  - On handshake:
    - read_addr += seg, write_addr += seg (wrap modulo 2**AXI_ADDR_WIDTH).
    - remaining -= seg, seq += 1, outstanding += 1.
  - Back-to-back issue: one descriptor per cycle when ready is held high and credits are available.
  - remaining reaches 0, or latched error nonzero -> WAIT_DONE (no further descriptors issued).
- Status handling, in all non-IDLE states:
  - status_valid decrements outstanding.
  - Simultaneous issue handshake and status -> outstanding unchanged.
  - First nonzero status_error is latched; later errors are ignored.
  - Status tags are not checked; the CDMA completes in order.
- WAIT_DONE: outstanding == 0 -> STATUS.
- STATUS:
  - m_axis_req_status_valid = 1 for exactly one cycle, with latched tag and error.
  - Next cycle -> IDLE.
  - Minimum gap between status pulse and next req accept: 1 cycle.
- Latency: req accept to first desc valid = 2 cycles; last completion to req status pulse = 2 cycles.

Test Plan:
- len=10000, MAX_SEG_LEN=4096, raddr=0x1000, waddr=0x8000, ready=1, immediate statuses -> descriptors (0x1000,0x8000,4096,tag0), (0x2000,0x9000,4096,tag1), (0x3000,0xA000,1808,tag2); one status pulse with error 0.
- Credit limit: len=40960 (10 segs), statuses withheld -> exactly 4 descriptors issued, valid stays low; release one status -> exactly one more descriptor.
- Error abort: 10-seg request, status error=3 on tag1 -> no new descriptors after error observed; after outstanding drains, status pulse error=3 with the request tag.
- len=0, tag=0x5A -> no descriptors; status pulse tag=0x5A error=0 two cycles after accept.
- Backpressure: ready low 5 cycles mid-transfer -> descriptor fields stable, no duplicates; simultaneous issue+status cycle keeps outstanding correct (check final status fires).
- Async reset asserted mid-ISSUE -> all valids low immediately; after release, new req len=100 completes with 1 descriptor; stale status ignored.
